product_accumulator: RTL and testbench

//  Sequential stage directly downstream of the generated combinational multiplier (Mult_<N>_<M>).

---
 rtl/mult_pkg.sv | 9 +
 rtl/product_accumulator_if.sv | 27 ++
 rtl/FullAdder.sv | 13 +
 rtl/HalfAdder.sv | 12 +
 rtl/acc_ripple_adder.sv | 32 +++
 rtl/product_accumulator.sv | 118 +++++++++++
 tb/tb_product_accumulator.sv | 287 ++++++++++++++++++++++++++++
 7 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and default widths for the multiplier/accumulator datapath
package mult_pkg;

    typedef enum logic {ACCUM, HOLD} acc_state_e;

    localparam int PW_DEF   = 6;
    localparam int ACCW_DEF = 8;

endpackage

// File: rtl/product_accumulator_if.sv
// rtl/product_accumulator_if.sv - product input / result output handshake bundle
interface product_accumulator_if
    import mult_pkg::*;
#(
    parameter int PW   = PW_DEF,
    parameter int ACCW = ACCW_DEF
);

    logic            in_valid;
    logic            in_ready;
    logic [PW-1:0]   in_prod;
    logic            out_valid;
    logic            out_ready;
    logic [ACCW-1:0] out_sum;
    logic            out_ovf;

    modport master (
        output in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );

endinterface

// File: rtl/FullAdder.sv
// rtl/FullAdder.sv - one-bit full adder cell
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/HalfAdder.sv
// rtl/HalfAdder.sv - one-bit half adder cell
module HalfAdder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/acc_ripple_adder.sv
// rtl/acc_ripple_adder.sv - W-bit ripple-carry adder built from half/full adder cells
module acc_ripple_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:1] carry;

    HalfAdder u_ha0 (
        .a (a[0]),
        .b (b[0]),
        .s (sum[0]),
        .c (carry[1])
    );

    for (genvar i = 1; i < W; i++) begin : g_fa
        FullAdder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[W];

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums LEN unsigned products per result, with sticky overflow
module product_accumulator
    import mult_pkg::*;
#(
    parameter int PW   = PW_DEF,
    parameter int ACCW = ACCW_DEF,
    parameter int LEN  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    product_accumulator_if.slave bus
);

    localparam int CW = $clog2(LEN + 1);

    acc_state_e      state_q, state_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [ACCW-1:0] sum_q, sum_d;
    logic            sum_ovf_q, sum_ovf_d;

    logic [ACCW-1:0] prod_ext;
    logic [ACCW-1:0] add_sum;
    logic            add_cout;
    logic            accept_in;
    logic            accept_out;

    assign prod_ext = ACCW'(bus.in_prod);

    acc_ripple_adder #(.W(ACCW)) u_add (
        .a    (acc_q),
        .b    (prod_ext),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign bus.out_valid = (state_q == HOLD);
    assign bus.in_ready  = (state_q == ACCUM) | bus.out_ready;
    assign bus.out_sum   = sum_q;
    assign bus.out_ovf   = sum_ovf_q;

    assign accept_in  = bus.in_valid & bus.in_ready;
    assign accept_out = bus.out_valid & bus.out_ready;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        sum_d     = sum_q;
        sum_ovf_d = sum_ovf_q;

        if (clr) begin
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = ACCUM;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (accept_in) begin
                        if (cnt_q == CW'(LEN - 1)) begin
                            sum_d     = add_sum;
                            sum_ovf_d = ovf_q | add_cout;
                            acc_d     = '0;
                            cnt_d     = '0;
                            ovf_d     = 1'b0;
                            state_d   = HOLD;
                        end else begin
                            acc_d = add_sum;
                            ovf_d = ovf_q | add_cout;
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    // acc is zero here, so add_sum is the bare product for the overlap case
                    if (accept_out) begin
                        state_d = ACCUM;
                        if (accept_in) begin
                            if (LEN == 1) begin
                                sum_d     = add_sum;
                                sum_ovf_d = add_cout;
                                state_d   = HOLD;
                            end else begin
                                acc_d = prod_ext;
                                cnt_d = CW'(1);
                                ovf_d = 1'b0;
                            end
                        end
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            sum_q     <= '0;
            sum_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            sum_q     <= sum_d;
            sum_ovf_q <= sum_ovf_d;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - randomized and directed checks of product_accumulator (LEN 4, 8, 1)
module tb_product_accumulator;

    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    logic       iv   [3];
    logic       ordy [3];
    logic       clrv [3];
    logic [5:0] ip   [3];
    logic       irdy [3];
    logic       ov   [3];
    logic       oovf [3];
    logic [7:0] osum [3];

    int lens [3] = '{4, 8, 1};

    bit m_hold [3];
    int m_sum  [3];
    int m_cnt  [3];
    int m_res  [3];
    bit m_ovf  [3];

    product_accumulator_if #(.PW(6), .ACCW(8)) if4 ();
    product_accumulator_if #(.PW(6), .ACCW(8)) if8 ();
    product_accumulator_if #(.PW(6), .ACCW(8)) if1 ();

    product_accumulator #(.PW(6), .ACCW(8), .LEN(4)) u4 (.clk(clk), .rst(rst), .clr(clrv[0]), .bus(if4));
    product_accumulator #(.PW(6), .ACCW(8), .LEN(8)) u8 (.clk(clk), .rst(rst), .clr(clrv[1]), .bus(if8));
    product_accumulator #(.PW(6), .ACCW(8), .LEN(1)) u1 (.clk(clk), .rst(rst), .clr(clrv[2]), .bus(if1));

    assign if4.in_valid = iv[0];  assign if4.in_prod = ip[0];  assign if4.out_ready = ordy[0];
    assign if8.in_valid = iv[1];  assign if8.in_prod = ip[1];  assign if8.out_ready = ordy[1];
    assign if1.in_valid = iv[2];  assign if1.in_prod = ip[2];  assign if1.out_ready = ordy[2];

    assign irdy[0] = if4.in_ready; assign ov[0] = if4.out_valid; assign osum[0] = if4.out_sum; assign oovf[0] = if4.out_ovf;
    assign irdy[1] = if8.in_ready; assign ov[1] = if8.out_valid; assign osum[1] = if8.out_sum; assign oovf[1] = if8.out_ovf;
    assign irdy[2] = if1.in_ready; assign ov[2] = if1.out_valid; assign osum[2] = if1.out_sum; assign oovf[2] = if1.out_ovf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear(input int k);
        m_hold[k] = 1'b0;
        m_sum[k]  = 0;
        m_cnt[k]  = 0;
        m_res[k]  = 0;
        m_ovf[k]  = 1'b0;
    endtask

    // One clock of DUT k: check registered outputs, drive inputs, check in_ready, advance the model.
    task automatic cycle(input int k, input logic v, input logic [5:0] p, input logic r, input logic c);
        logic       exp_rdy;
        logic       acc_in;
        logic       acc_out;
        logic [7:0] want_sum;
        @(negedge clk);
        vectors++;
        if (ov[k] !== logic'(m_hold[k])) begin
            miscompares++;
            $display("FAIL k%0d out_valid: got %b want %b", k, ov[k], m_hold[k]);
        end
        if (m_hold[k]) begin
            want_sum = 8'(m_res[k]);
            vectors++;
            if (osum[k] !== want_sum) begin
                miscompares++;
                $display("FAIL k%0d out_sum: got %0d want %0d", k, osum[k], want_sum);
            end
            vectors++;
            if (oovf[k] !== logic'(m_ovf[k])) begin
                miscompares++;
                $display("FAIL k%0d out_ovf: got %b want %b", k, oovf[k], m_ovf[k]);
            end
        end
        iv[k]   = v;
        ip[k]   = p;
        ordy[k] = r;
        clrv[k] = c;
        #1;
        exp_rdy = !m_hold[k] || r;
        vectors++;
        if (irdy[k] !== exp_rdy) begin
            miscompares++;
            $display("FAIL k%0d in_ready: got %b want %b", k, irdy[k], exp_rdy);
        end
        acc_out = m_hold[k] && r;
        acc_in  = v && exp_rdy;
        if (c) begin
            m_hold[k] = 1'b0;
            m_sum[k]  = 0;
            m_cnt[k]  = 0;
        end else begin
            if (acc_out) m_hold[k] = 1'b0;
            if (acc_in) begin
                m_sum[k] += int'(p);
                m_cnt[k]++;
                if (m_cnt[k] == lens[k]) begin
                    m_res[k]  = m_sum[k] % 256;
                    m_ovf[k]  = (m_sum[k] > 255);
                    m_hold[k] = 1'b1;
                    m_sum[k]  = 0;
                    m_cnt[k]  = 0;
                end
            end
        end
    endtask

    task automatic test_reset;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (ov[k] !== 1'b0 || osum[k] !== 8'd0 || oovf[k] !== 1'b0 || irdy[k] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_state k%0d: got v=%b s=%0d o=%b r=%b want 0 0 0 1",
                         k, ov[k], osum[k], oovf[k], irdy[k]);
            end
        end
        cycle(0, 1, 6'd7, 1, 0);
        cycle(0, 1, 6'd9, 1, 0);
        cycle(0, 0, 6'd0, 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0; clrv[k] = 1'b0;
            model_clear(k);
        end
        #1;
        vectors++;
        if (ov[0] !== 1'b0 || osum[0] !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_mid_group: got v=%b s=%0d want 0 0", ov[0], osum[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cycle(0, 1, 6'd1, 1, 0);
        @(posedge clk);
        #1;
        vectors++;
        if (ov[0] !== 1'b1 || osum[0] !== 8'd4) begin
            miscompares++;
            $display("FAIL reset_cnt_cleared: got v=%b s=%0d want 1 4", ov[0], osum[0]);
        end
        cycle(0, 0, 6'd0, 1, 0);
        cycle(0, 0, 6'd0, 0, 0);
    endtask

    task automatic test_basic_and_backpressure;
        logic [5:0] pv [4] = '{6'd7, 6'd9, 6'd4, 6'd1};
        cycle(0, 0, 6'd0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(0, 1, pv[i], 0, 0);
        @(posedge clk);
        #1;
        vectors++;
        if (ov[0] !== 1'b1 || osum[0] !== 8'd21 || oovf[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_sum: got v=%b s=%0d o=%b want 1 21 0", ov[0], osum[0], oovf[0]);
        end
        for (int i = 0; i < 3; i++) cycle(0, 1, 6'd5, 0, 0);
        @(posedge clk);
        #1;
        vectors++;
        if (osum[0] !== 8'd21 || irdy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure_hold: got s=%0d r=%b want 21 0", osum[0], irdy[0]);
        end
        for (int i = 0; i < 4; i++) cycle(0, 1, 6'd5, 1, 0);
        @(posedge clk);
        #1;
        vectors++;
        if (ov[0] !== 1'b1 || osum[0] !== 8'd20) begin
            miscompares++;
            $display("FAIL after_backpressure: got v=%b s=%0d want 1 20", ov[0], osum[0]);
        end
        cycle(0, 0, 6'd0, 0, 0);
    endtask

    task automatic test_overflow;
        cycle(1, 0, 6'd0, 0, 1);
        for (int i = 0; i < 8; i++) cycle(1, 1, 6'd49, 0, 0);
        @(posedge clk);
        #1;
        vectors++;
        if (osum[1] !== 8'd136 || oovf[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow: got s=%0d o=%b want 136 1", osum[1], oovf[1]);
        end
        for (int i = 0; i < 8; i++) cycle(1, 1, 6'd1, 1, 0);
        @(posedge clk);
        #1;
        vectors++;
        if (osum[1] !== 8'd8 || oovf[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_cleared: got s=%0d o=%b want 8 0", osum[1], oovf[1]);
        end
        cycle(1, 0, 6'd0, 0, 0);
    endtask

    task automatic test_back_to_back;
        logic [5:0] pv [4] = '{6'd3, 6'd2, 6'd2, 6'd2};
        logic [7:0] want1 [3] = '{8'd6, 8'd0, 8'd36};
        cycle(0, 0, 6'd0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(0, 1, 6'd1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, pv[i], 1, 0);
        @(posedge clk);
        #1;
        vectors++;
        if (ov[0] !== 1'b1 || osum[0] !== 8'd9) begin
            miscompares++;
            $display("FAIL overlap_sum: got v=%b s=%0d want 1 9", ov[0], osum[0]);
        end
        cycle(0, 0, 6'd0, 0, 0);
        cycle(2, 0, 6'd0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(2, 1, want1[i][5:0], 1, 0);
            @(posedge clk);
            #1;
            vectors++;
            if (ov[2] !== 1'b1 || osum[2] !== want1[i]) begin
                miscompares++;
                $display("FAIL len1_stream[%0d]: got v=%b s=%0d want 1 %0d", i, ov[2], osum[2], want1[i]);
            end
        end
        cycle(2, 0, 6'd0, 0, 0);
    endtask

    task automatic test_clr;
        cycle(0, 0, 6'd0, 0, 1);
        cycle(0, 1, 6'd7, 1, 0);
        cycle(0, 1, 6'd9, 1, 0);
        cycle(0, 1, 6'd30, 1, 1);
        for (int i = 0; i < 4; i++) cycle(0, 1, 6'd1, 0, 0);
        @(posedge clk);
        #1;
        vectors++;
        if (ov[0] !== 1'b1 || osum[0] !== 8'd4) begin
            miscompares++;
            $display("FAIL clr_discard: got v=%b s=%0d want 1 4", ov[0], osum[0]);
        end
        cycle(0, 0, 6'd0, 0, 1);
        @(posedge clk);
        #1;
        vectors++;
        if (ov[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_in_hold: got v=%b want 0", ov[0]);
        end
        cycle(0, 0, 6'd0, 0, 0);
    endtask

    task automatic test_random;
        for (int k = 0; k < 3; k++) begin
            cycle(k, 0, 6'd0, 0, 1);
            repeat (150) begin
                cycle(k, $urandom_range(0, 3) != 0, 6'($urandom), $urandom_range(0, 3) != 0,
                      $urandom_range(0, 29) == 0);
            end
            cycle(k, 0, 6'd0, 0, 0);
            cycle(k, 0, 6'd0, 0, 0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0; clrv[k] = 1'b0; ip[k] = '0;
            model_clear(k);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        test_reset();
        test_basic_and_backpressure();
        test_overflow();
        test_back_to_back();
        test_clr();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
